pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit. It holds the PC register and computes the next PC for sequential, PC-relative branch, PC-relative jump and register-indirect jump flow.
- Adds stall, sticky halt, misalignment detection and a small return-address stack (RAS) for link/return.
- Sits at the front of the fetch stage: drives the instruction-memory address, and returns pc_plus2 to the register file for link writes.

Parameters:
- W, 16, PC and datapath width in bits.
- IW_I, 8, width of the short (branch / register-jump) immediate.
- IW_D, 11, width of the long (jump) displacement.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- halt  in  1  enter halted state.
- mode  in  2  00 seq, 01 branch (PC+2+sext(imm_i)), 10 jump (PC+2+sext(imm_d)), 11 reg jump (rs_val+sext(imm_i)).
- take  in  1  branch condition; only qualifies mode 01.
- imm_i  in  IW_I  short immediate, two's complement.
- imm_d  in  IW_D  long displacement, two's complement.
- rs_val  in  W  register operand for mode 11.
- link  in  1  push pc_plus2 onto RAS when the redirect commits.
- ret  in  1  use RAS top as the target and pop.
- pc  out  W  current PC (registered).
- pc_plus2  out  W  pc + 2, combinational from pc.
- halted  out  1  sticky halt status.
- misalign  out  1  one-cycle registered pulse: computed target had bit0 = 1.
- ras_underflow  out  1  one-cycle registered pulse: ret with empty RAS.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC.
  - halted = 0, misalign = 0, ras_underflow = 0, ras_count = 0.
  - RAS pointer = 0. RAS contents are don't-care.
- Arithmetic:
  - All adds are modulo 2^W; wrap-around is silent (0xFFFE + 2 = 0x0000).
  - imm_i and imm_d are sign-extended from their MSB to W.
- Target selection (combinational), priority high to low:
  - ret with ras_count>0 -> RAS top.
  - mode 11 -> rs_val + sext(imm_i).
  - mode 10 -> pc_plus2 + sext(imm_d).
  - mode 01 with take=1 -> pc_plus2 + sext(imm_i).
  - otherwise -> pc_plus2.
  - take is ignored in modes 00, 10 and 11.
- Commit: on a rising edge with halted=0, halt=0 and stall=0:
  - pc <= target with bit0 forced to 0.
  - misalign <= target[0].
- Redirect: a commit whose target is not pc_plus2-by-default, i.e. any of modes 01-taken, 10, 11, or a ret hit.
- Stall=1:
  - pc, RAS and ras_count hold.
  - misalign and ras_underflow deassert next cycle (pulses never stretch).
- Halt:
  - halt=1 on an edge sets halted=1 regardless of stall; pc holds.
  - halted stays 1 until reset, and all further commits are blocked.
  - A halt edge coinciding with a redirect suppresses the redirect.
- RAS push:
  - Occurs on a committed redirect with link=1.
  - Writes pc_plus2 at the pointer, pointer+1 mod RAS_DEPTH, ras_count = min(count+1, RAS_DEPTH).
  - Full-stack push overwrites the oldest entry (circular).
  - link with mode 00, or mode 01 with take=0, is ignored.
- RAS pop:
  - Occurs on a committed ret with count>0: pointer-1, count-1.
  - ret with count=0: no pop; target falls through to the mode selection; ras_underflow pulses next cycle.
- ret and link in the same committed cycle: pop, then push; the top entry is replaced by pc_plus2 and the count is unchanged.
- Reset mid-stall or mid-halt returns to the reset state immediately.
- Latency: target to pc takes 1 cycle; pc to pc_plus2 takes 0 cycles.

Decomposition:
- Shared package: mode encodings (PC_SEQ=2'b00, PC_BR=2'b01, PC_JMP=2'b10, PC_RJMP=2'b11) and the increment constant 2.
- Sub-module ras_stack, parametrised by W and RAS_DEPTH:
  - Inputs: push, pop, push_data.
  - Outputs: top, count.
  - Circular overwrite on full.
- Sign extension and adds stay inline.

Test Plan:
- Reset then 3 free-running cycles, mode=00, RESET_PC=0 -> pc 0x0000, 0x0002, 0x0004, 0x0006. pc_plus2 always tracks pc+2.
- pc=0x0010:
  - mode=01, imm_i=0xFC, take=1 -> pc=0x000E.
  - Same stimulus with take=0 -> pc=0x0012.
- pc=0x0100, mode=10, imm_d=0x400 (-1024) -> pc=0xFD02 (wrap).
- Register-jump misalign: mode=11, rs_val=0x2001, imm_i=0x02 -> pc=0x2002, misalign=1 for exactly one cycle.
- RAS, RAS_DEPTH=4:
  - 5 linked jumps from pc 0x10, 0x20, 0x30, 0x40, 0x50 -> count saturates at 4.
  - 4 rets -> pc 0x0052, 0x0042, 0x0032, 0x0022.
  - 5th ret with mode=00 -> pc=pc+2, ras_underflow pulses once.
- Stall and halt:
  - stall=1 for 2 cycles with mode=10 -> pc and ras_count hold.
  - halt asserted alongside a taken branch -> pc unchanged, halted=1 sticky.
  - rst=0 mid-cycle -> pc=RESET_PC, halted=0 asynchronously.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: flow-mode encodings
// and the sequential instruction increment.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JMP  = 2'b10,
        PC_RJMP = 2'b11
    } pc_mode_e;

    localparam int PC_INC = 2;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push writes at the pointer, pop steps back,
// and a push onto a full stack silently overwrites the oldest entry.
module ras_stack #(
    parameter int W         = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int            PW   = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(RAS_DEPTH);

    logic [W-1:0]  r_mem [RAS_DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_count;

    logic          w_pop;
    logic [PW-1:0] w_top_idx;
    logic [PW-1:0] w_wr_idx;

    assign w_pop     = pop && (r_count != '0);
    assign w_top_idx = r_ptr - 1'b1;
    // Pop-then-push lands on the slot just vacated, replacing the top in place.
    assign w_wr_idx  = w_pop ? w_top_idx : r_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= (r_count == FULL) ? r_count : r_count + 1'b1;
                end
                2'b01: begin
                    r_ptr   <= r_ptr - 1'b1;
                    r_count <= r_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read once counted
    // valid, so clearing them would cost a reset net on every bit for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign top   = r_mem[w_top_idx];
    assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Front-of-fetch program counter: selects sequential, branch, jump, register
// jump or return target, with stall, sticky halt and a return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int             W         = 16,
    parameter int             IW_I      = 8,
    parameter int             IW_D      = 11,
    parameter logic [W-1:0]   RESET_PC  = '0,
    parameter int             RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         halt,
    input  logic [1:0]                   mode,
    input  logic                         take,
    input  logic [IW_I-1:0]              imm_i,
    input  logic [IW_D-1:0]              imm_d,
    input  logic [W-1:0]                 rs_val,
    input  logic                         link,
    input  logic                         ret,
    output logic [W-1:0]                 pc,
    output logic [W-1:0]                 pc_plus2,
    output logic                         halted,
    output logic                         misalign,
    output logic                         ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    logic [W-1:0] r_pc;
    logic         r_halted;
    logic         r_misalign;
    logic         r_ras_underflow;

    pc_mode_e                   w_mode;
    logic [W-1:0]               w_pc_plus2;
    logic [W-1:0]               w_sext_i;
    logic [W-1:0]               w_sext_d;
    logic [W-1:0]               w_target;
    logic [W-1:0]               w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;
    logic                       w_ret_hit;
    logic                       w_redirect;
    logic                       w_commit;

    assign w_mode     = pc_mode_e'(mode);
    assign w_pc_plus2 = r_pc + W'(PC_INC);
    assign w_sext_i   = {{(W-IW_I){imm_i[IW_I-1]}}, imm_i};
    assign w_sext_d   = {{(W-IW_D){imm_d[IW_D-1]}}, imm_d};
    assign w_ret_hit  = ret && (w_ras_count != '0);
    assign w_commit   = !r_halted && !halt && !stall;
    assign w_redirect = w_ret_hit || (w_mode == PC_RJMP) || (w_mode == PC_JMP) ||
                        ((w_mode == PC_BR) && take);

    // NOTE: the default is assigned before the branches so no path leaves the
    // target unassigned, which would otherwise infer a latch.
    always_comb begin
        w_target = w_pc_plus2;
        if (w_ret_hit) begin
            w_target = w_ras_top;
        end else begin
            case (w_mode)
                PC_RJMP: w_target = rs_val + w_sext_i;
                PC_JMP:  w_target = w_pc_plus2 + w_sext_d;
                PC_BR:   if (take) w_target = w_pc_plus2 + w_sext_i;
                default: ;
            endcase
        end
    end

    ras_stack #(
        .W         (W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_commit && w_redirect && link),
        .pop       (w_commit && w_ret_hit),
        .push_data (w_pc_plus2),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc            <= RESET_PC;
            r_halted        <= 1'b0;
            r_misalign      <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_halted        <= r_halted | halt;
            r_misalign      <= w_commit & w_target[0];
            r_ras_underflow <= w_commit & ret & ~w_ret_hit;
            if (w_commit) begin
                r_pc <= {w_target[W-1:1], 1'b0};
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus2      = w_pc_plus2;
    assign halted        = r_halted;
    assign misalign      = r_misalign;
    assign ras_underflow = r_ras_underflow;
    assign ras_count     = w_ras_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_sequencer;

    localparam int W = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, halt, take, link, ret;
    logic [1:0]    mode;
    logic [7:0]    imm_i;
    logic [10:0]   imm_d;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  pc, pc_plus2;
    logic          halted, misalign, ras_underflow;
    logic [2:0]    ras_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  m_pc;
    logic          m_halted, m_mis, m_uf;
    logic [W-1:0]  m_ras[$];

    pc_sequencer #(
        .W(16), .IW_I(8), .IW_D(11), .RESET_PC(16'h0000), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .mode(mode),
        .take(take), .imm_i(imm_i), .imm_d(imm_d), .rs_val(rs_val),
        .link(link), .ret(ret), .pc(pc), .pc_plus2(pc_plus2),
        .halted(halted), .misalign(misalign), .ras_underflow(ras_underflow),
        .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] obs();
        return {pc, pc_plus2, halted, misalign, ras_underflow, ras_count};
    endfunction

    function automatic logic [37:0] expect_obs();
        return {m_pc, m_pc + 16'd2, m_halted, m_mis, m_uf, 3'(m_ras.size())};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        m_halted = 1'b0;
        m_mis = 1'b0;
        m_uf = 1'b0;
        m_ras.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [W-1:0] pp2, t;
        logic hit, redir, commit;
        pp2 = m_pc + 16'd2;
        hit = ret && (m_ras.size() > 0);
        if (hit)            t = m_ras[$];
        else if (mode == 3) t = 16'(int'(rs_val) + int'($signed(imm_i)));
        else if (mode == 2) t = 16'(int'(pp2) + int'($signed(imm_d)));
        else if (mode == 1 && take) t = 16'(int'(pp2) + int'($signed(imm_i)));
        else                t = pp2;
        redir  = hit || mode == 3 || mode == 2 || (mode == 1 && take);
        commit = !m_halted && !halt && !stall;
        m_mis = commit && t[0];
        m_uf  = commit && ret && !hit;
        if (halt) m_halted = 1'b1;
        if (commit) begin
            if (hit) void'(m_ras.pop_back());
            if (redir && link) begin
                m_ras.push_back(pp2);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = t & 16'hFFFE;
        end
    endtask

    task automatic idle();
        stall = 0; halt = 0; take = 0; link = 0; ret = 0;
        mode = 2'b00; imm_i = '0; imm_d = '0; rs_val = '0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic goto_pc(input logic [W-1:0] addr);
        idle();
        mode = 2'b11;
        rs_val = addr;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #1;
        @(posedge clk);
        #1;
        model_reset();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
        total++; if (pc_plus2 !== 16'h0002) begin bad++; $display("FAIL reset_pc_plus2: got %h want 0002", pc_plus2); end
        total++; if ({halted, misalign, ras_underflow} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {halted, misalign, ras_underflow}); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_ras_count: got %0d want 0", ras_count); end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        idle();
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (pc !== 16'(2 * i)) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 16'(2 * i)); end
            total++; if (pc_plus2 !== 16'(2 * i + 2)) begin bad++; $display("FAIL seq_pc_plus2[%0d]: got %h want %h", i, pc_plus2, 16'(2 * i + 2)); end
        end
    endtask

    task automatic test_branch();
        goto_pc(16'h0010);
        mode = 2'b01; imm_i = 8'hFC; take = 1;
        step();
        total++; if (pc !== 16'h000E) begin bad++; $display("FAIL branch_taken: got %h want 000E", pc); end
        goto_pc(16'h0010);
        mode = 2'b01; imm_i = 8'hFC; take = 0;
        step();
        total++; if (pc !== 16'h0012) begin bad++; $display("FAIL branch_not_taken: got %h want 0012", pc); end
        mode = 2'b00; take = 1; imm_i = 8'h40;
        step();
        total++; if (pc !== 16'h0014) begin bad++; $display("FAIL take_ignored_seq: got %h want 0014", pc); end
    endtask

    task automatic test_jump_wrap();
        goto_pc(16'h0100);
        mode = 2'b10; imm_d = 11'h400;
        step();
        total++; if (pc !== 16'hFD02) begin bad++; $display("FAIL jump_wrap: got %h want FD02", pc); end
        goto_pc(16'hFFFE);
        step();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL seq_wrap: got %h want 0000", pc); end
    endtask

    task automatic test_rjmp_misalign();
        idle();
        mode = 2'b11; rs_val = 16'h2001; imm_i = 8'h02;
        step();
        total++; if (pc !== 16'h2002 || misalign !== 1'b1) begin bad++; $display("FAIL misalign_set: got pc=%h mis=%b want pc=2002 mis=1", pc, misalign); end
        idle();
        step();
        total++; if (misalign !== 1'b0 || pc !== 16'h2004) begin bad++; $display("FAIL misalign_pulse: got pc=%h mis=%b want pc=2004 mis=0", pc, misalign); end
    endtask

    task automatic test_ras();
        do_reset();
        goto_pc(16'h0010);
        for (int k = 0; k < 5; k++) begin
            mode = 2'b11; rs_val = 16'(16'h20 + 16'h10 * k); link = 1;
            step();
            total++; if (ras_count !== 3'((k + 1 > 4) ? 4 : k + 1)) begin bad++; $display("FAIL ras_push_count[%0d]: got %0d want %0d", k, ras_count, (k + 1 > 4) ? 4 : k + 1); end
        end
        for (int k = 0; k < 4; k++) begin
            idle(); ret = 1;
            step();
            total++; if (pc !== 16'(16'h52 - 16'h10 * k) || ras_count !== 3'(3 - k)) begin bad++; $display("FAIL ras_pop[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d", k, pc, ras_count, 16'(16'h52 - 16'h10 * k), 3 - k); end
        end
        idle(); ret = 1;
        step();
        total++; if (pc !== 16'h0024 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin bad++; $display("FAIL ras_underflow: got pc=%h uf=%b cnt=%0d want pc=0024 uf=1 cnt=0", pc, ras_underflow, ras_count); end
        idle();
        step();
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL ras_underflow_pulse: got %b want 0", ras_underflow); end
    endtask

    task automatic test_ret_link();
        do_reset();
        goto_pc(16'h0010);
        mode = 2'b11; rs_val = 16'h0020; link = 1;
        step();
        idle(); ret = 1; link = 1;
        step();
        total++; if (pc !== 16'h0012 || ras_count !== 3'd1) begin bad++; $display("FAIL ret_link: got pc=%h cnt=%0d want pc=0012 cnt=1", pc, ras_count); end
        idle(); ret = 1;
        step();
        total++; if (pc !== 16'h0022 || ras_count !== 3'd0) begin bad++; $display("FAIL ret_link_top: got pc=%h cnt=%0d want pc=0022 cnt=0", pc, ras_count); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mode   = 2'($urandom);
            take   = 1'($urandom);
            imm_i  = 8'($urandom);
            imm_d  = 11'($urandom);
            rs_val = 16'($urandom);
            link   = ($urandom_range(0, 2) == 0);
            ret    = ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 7) == 0);
            halt   = 1'b0;
            step();
            total++;
            if (obs() !== expect_obs()) begin
                bad++;
                errs++;
                if (errs <= 10) $display("FAIL random[%0d]: got %h want %h", n, obs(), expect_obs());
            end
        end
        idle();
    endtask

    task automatic test_stall_halt();
        logic [W-1:0] held_pc;
        do_reset();
        goto_pc(16'h0030);
        mode = 2'b11; rs_val = 16'h0040; link = 1;
        step();
        held_pc = 16'h0040;
        idle(); stall = 1; mode = 2'b10; imm_d = 11'h010; link = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (pc !== held_pc || ras_count !== 3'd1) begin bad++; $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d want pc=%h cnt=1", k, pc, ras_count, held_pc); end
        end
        idle(); mode = 2'b01; take = 1; imm_i = 8'h10; halt = 1;
        step();
        total++; if (pc !== held_pc || halted !== 1'b1) begin bad++; $display("FAIL halt_enter: got pc=%h halted=%b want pc=%h halted=1", pc, halted, held_pc); end
        idle(); mode = 2'b10; imm_d = 11'h020;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (pc !== held_pc || halted !== 1'b1 || obs() !== expect_obs()) begin bad++; $display("FAIL halt_sticky[%0d]: got pc=%h halted=%b want pc=%h halted=1", k, pc, halted, held_pc); end
        end
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        total++; if (pc !== 16'h0000 || halted !== 1'b0 || ras_count !== 3'd0) begin bad++; $display("FAIL async_reset: got pc=%h halted=%b cnt=%0d want pc=0000 halted=0 cnt=0", pc, halted, ras_count); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        step();
        total++; if (pc !== 16'h0002 || halted !== 1'b0) begin bad++; $display("FAIL post_reset_run: got pc=%h halted=%b want pc=0002 halted=0", pc, halted); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_wrap();
        test_rjmp_misalign();
        test_ras();
        test_ret_link();
        test_random();
        test_stall_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
